// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I field tuples back into 32-bit instruction
// words and buffers them in a small FIFO behind valid/ready handshakes.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_valid / o_ready       tuple input handshake (o_ready = FIFO not full)
//   i_format                one-hot {J,U,B,S,I,R}
//   i_opcode .. i_imm       decoded instruction fields
//   o_valid / i_ready       word output handshake (o_valid = FIFO not empty)
//   o_inst, o_err           head word and its illegal flag
//   o_count                 number of words popped, wraps modulo 2^CNT_W
//
// Optional feature macro: INST_ENC_RANGE_CHECK_EN
//   defined   - immediates that do not fit their field make the tuple illegal
//   undefined - upper immediate bits are truncated, B/J low bit dropped
//
// Illegal tuples are replaced by NOP (0x00000013) with o_err=1, still queued.

module inst_encoder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [5:0]       i_format,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [6:0]       i_funct7,
    input  logic [4:0]       i_rd,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [31:0]      i_imm,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_inst,
    output logic             o_err,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    localparam logic [5:0] FMT_R = 6'b000001;
    localparam logic [5:0] FMT_I = 6'b000010;
    localparam logic [5:0] FMT_S = 6'b000100;
    localparam logic [5:0] FMT_B = 6'b001000;
    localparam logic [5:0] FMT_U = 6'b010000;
    localparam logic [5:0] FMT_J = 6'b100000;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // ------------------------------------------------------------------
    // Encoder (combinational, feeds FIFO write data only)
    // ------------------------------------------------------------------
    logic        fmt_onehot_c;
    logic        op_ok_c;
    logic        range_ok_c;
    logic        is_shift_c;
    logic [31:0] word_c;
    logic        legal_c;
    logic [31:0] enc_inst_c;
    logic        enc_err_c;

`ifdef INST_ENC_RANGE_CHECK_EN
    logic imm_fits12_c;
    logic imm_fits13_c;
    logic imm_fits21_c;

    // Sign-extension checks: the bits above the field must all match.
    always_comb begin
        imm_fits12_c = (&i_imm[31:11]) | ~(|i_imm[31:11]);
        imm_fits13_c = (&i_imm[31:12]) | ~(|i_imm[31:12]);
        imm_fits21_c = (&i_imm[31:20]) | ~(|i_imm[31:20]);
    end
`endif

    // A format vector is one-hot when non-zero with a single bit set.
    always_comb begin
        fmt_onehot_c = (i_format != 6'd0) &&
                       ((i_format & (i_format - 6'd1)) == 6'd0);
        is_shift_c   = (i_opcode == OP_IMM) &&
                       ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));
    end

    // Field packing and opcode/format consistency per format.
    always_comb begin
        word_c     = 32'd0;
        op_ok_c    = 1'b0;
        range_ok_c = 1'b1;
        case (i_format)
            FMT_R: begin
                word_c  = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                op_ok_c = (i_opcode == OP_REG);
            end
            FMT_I: begin
                if (is_shift_c) begin
                    word_c = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
                end else begin
                    word_c = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                end
                op_ok_c = (i_opcode == OP_IMM) || (i_opcode == OP_LOAD);
`ifdef INST_ENC_RANGE_CHECK_EN
                range_ok_c = imm_fits12_c;
`endif
            end
            FMT_S: begin
                word_c  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                op_ok_c = (i_opcode == OP_STORE);
`ifdef INST_ENC_RANGE_CHECK_EN
                range_ok_c = imm_fits12_c;
`endif
            end
            FMT_B: begin
                word_c  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
                op_ok_c = (i_opcode == OP_BRANCH);
`ifdef INST_ENC_RANGE_CHECK_EN
                range_ok_c = imm_fits13_c && !i_imm[0];
`endif
            end
            FMT_U: begin
                word_c  = {i_imm[31:12], i_rd, i_opcode};
                op_ok_c = (i_opcode == OP_LUI) || (i_opcode == OP_AUIPC);
`ifdef INST_ENC_RANGE_CHECK_EN
                range_ok_c = (i_imm[11:0] == 12'd0);
`endif
            end
            FMT_J: begin
                word_c  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                           i_rd, i_opcode};
                op_ok_c = (i_opcode == OP_JAL);
`ifdef INST_ENC_RANGE_CHECK_EN
                range_ok_c = imm_fits21_c && !i_imm[0];
`endif
            end
            default: begin
                word_c  = 32'd0;
                op_ok_c = 1'b0;
            end
        endcase
    end

    // Illegal tuples collapse to a flagged NOP.
    always_comb begin
        legal_c    = fmt_onehot_c && op_ok_c && range_ok_c;
        enc_inst_c = legal_c ? word_c : NOP_WORD;
        enc_err_c  = !legal_c;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [31:0]      mem_inst_q [DEPTH];
    logic             mem_err_q  [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_c;
    logic             pop_c;

    // Handshakes use only registered status, so full blocks a push even
    // when a pop frees an entry in the same cycle.
    always_comb begin
        push_c = i_valid && ready_q;
        pop_c  = valid_q && i_ready;
    end

    // Pointer, occupancy and status next-state; DEPTH is a power of two so
    // pointers wrap naturally.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        occ_d   = occ_q + OW'(push_c) - OW'(pop_c);
        if (push_c) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + AW'(1);
            cnt_d  = cnt_q + CNT_W'(1);
        end
        valid_d = (occ_d != OW'(0));
        ready_d = (occ_d != OW'(DEPTH));
    end

    // Control state; ready stays low during reset and rises on the first edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_inst_q[i] <= 32'd0;
                mem_err_q[i]  <= 1'b0;
            end
        end else if (push_c) begin
            mem_inst_q[wptr_q] <= enc_inst_c;
            mem_err_q[wptr_q]  <= enc_err_c;
        end
    end

    always_comb begin
        o_valid = valid_q;
        o_ready = ready_q;
        o_inst  = mem_inst_q[rptr_q];
        o_err   = mem_err_q[rptr_q];
        o_count = cnt_q;
    end

endmodule
